swerv_axi_ar_arbiter: RTL and testbench

Shares the core's single AXI read-address (AR) channel between the instruction-fetch unit (IFU) and the load/store unit (LSU) inside the `swerv` wrapper. Requests are arbitrated round-robin and registered into one AR output slot. The block tracks outstanding reads per requester and steers R-channel beats back to their source by the ID MSB. R data and response fields do not pass through this block; only the handshake and ID routing do.

---
 rtl/swerv_axi_ar_arbiter.sv | 135 +++++++++++++
 tb/tb_swerv_axi_ar_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swerv_axi_ar_arbiter.sv
// Round-robin arbiter sharing one AXI AR channel between the IFU and LSU,
// with per-source outstanding-read tracking and ID-MSB based R routing.
module swerv_axi_ar_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int ID_W    = 3,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst_l,

    input  logic              ifu_ar_valid,
    output logic              ifu_ar_ready,
    input  logic [ADDR_W-1:0] ifu_ar_addr,
    input  logic [ID_W-1:0]   ifu_ar_id,

    input  logic              lsu_ar_valid,
    output logic              lsu_ar_ready,
    input  logic [ADDR_W-1:0] lsu_ar_addr,
    input  logic [ID_W-1:0]   lsu_ar_id,

    output logic              axi_arvalid,
    input  logic              axi_arready,
    output logic [ADDR_W-1:0] axi_araddr,
    output logic [ID_W:0]     axi_arid,

    input  logic              axi_rvalid,
    input  logic              axi_rlast,
    input  logic [ID_W:0]     axi_rid,
    output logic              axi_rready,

    output logic              ifu_r_valid,
    input  logic              ifu_r_ready,
    output logic              lsu_r_valid,
    input  logic              lsu_r_ready,
    output logic [ID_W-1:0]   r_id,

    output logic              err_unexpected_r
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state;
    logic             last_lsu;
    logic [CNT_W-1:0] cnt_ifu;
    logic [CNT_W-1:0] cnt_lsu;

    logic slot_free;
    logic ifu_elig;
    logic lsu_elig;
    logic grant_ifu;
    logic grant_lsu;
    logic accept;
    logic ar_hs;
    logic r_last_hs;
    logic inc_ifu;
    logic inc_lsu;
    logic dec_ifu;
    logic dec_lsu;

    assign axi_arvalid = (state == ST_FULL);
    assign slot_free   = !axi_arvalid || axi_arready;

    // Eligibility uses registered counts, so a same-cycle R completion does not unblock.
    assign ifu_elig = ifu_ar_valid && (cnt_ifu < MAX_CNT);
    assign lsu_elig = lsu_ar_valid && (cnt_lsu < MAX_CNT);

    assign grant_ifu = slot_free && ifu_elig && (!lsu_elig || last_lsu);
    assign grant_lsu = slot_free && lsu_elig && (!ifu_elig || !last_lsu);
    assign accept    = grant_ifu || grant_lsu;

    assign ifu_ar_ready = grant_ifu;
    assign lsu_ar_ready = grant_lsu;

    assign ar_hs     = axi_arvalid && axi_arready;
    assign r_last_hs = axi_rvalid && axi_rready && axi_rlast;
    assign inc_ifu   = ar_hs && !axi_arid[ID_W];
    assign inc_lsu   = ar_hs && axi_arid[ID_W];
    assign dec_ifu   = r_last_hs && !axi_rid[ID_W];
    assign dec_lsu   = r_last_hs && axi_rid[ID_W];

    assign ifu_r_valid = axi_rvalid && !axi_rid[ID_W];
    assign lsu_r_valid = axi_rvalid && axi_rid[ID_W];
    assign axi_rready  = axi_rid[ID_W] ? lsu_r_ready : ifu_r_ready;
    assign r_id        = axi_rid[ID_W-1:0];

    // Slot contents only change on acceptance, so they hold stable under backpressure.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state      <= ST_EMPTY;
            axi_araddr <= '0;
            axi_arid   <= '0;
            last_lsu   <= 1'b1;
        end else begin
            if (accept) begin
                state      <= ST_FULL;
                axi_araddr <= grant_lsu ? lsu_ar_addr : ifu_ar_addr;
                axi_arid   <= {grant_lsu, (grant_lsu ? lsu_ar_id : ifu_ar_id)};
                last_lsu   <= grant_lsu;
            end else if (ar_hs) begin
                state <= ST_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt_ifu          <= '0;
            cnt_lsu          <= '0;
            err_unexpected_r <= 1'b0;
        end else begin
            if (inc_ifu && !dec_ifu) begin
                cnt_ifu <= cnt_ifu + CNT_ONE;
            end else if (dec_ifu && !inc_ifu && (cnt_ifu != '0)) begin
                cnt_ifu <= cnt_ifu - CNT_ONE;
            end

            if (inc_lsu && !dec_lsu) begin
                cnt_lsu <= cnt_lsu + CNT_ONE;
            end else if (dec_lsu && !inc_lsu && (cnt_lsu != '0)) begin
                cnt_lsu <= cnt_lsu - CNT_ONE;
            end

            // A last beat for a source with nothing outstanding is sticky until reset.
            if ((dec_ifu && (cnt_ifu == '0)) || (dec_lsu && (cnt_lsu == '0))) begin
                err_unexpected_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_swerv_axi_ar_arbiter.sv
// Directed testbench for swerv_axi_ar_arbiter: arbitration, outstanding limits,
// backpressure, R routing, unexpected-beat error and asynchronous reset.
module tb_swerv_axi_ar_arbiter;

    logic        clk;
    logic        rst_l;
    logic        ifu_ar_valid;
    logic        ifu_ar_ready;
    logic [31:0] ifu_ar_addr;
    logic [2:0]  ifu_ar_id;
    logic        lsu_ar_valid;
    logic        lsu_ar_ready;
    logic [31:0] lsu_ar_addr;
    logic [2:0]  lsu_ar_id;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_araddr;
    logic [3:0]  axi_arid;
    logic        axi_rvalid;
    logic        axi_rlast;
    logic [3:0]  axi_rid;
    logic        axi_rready;
    logic        ifu_r_valid;
    logic        ifu_r_ready;
    logic        lsu_r_valid;
    logic        lsu_r_ready;
    logic [2:0]  r_id;
    logic        err_unexpected_r;

    int checks = 0;
    int errors = 0;

    swerv_axi_ar_arbiter #(
        .ADDR_W (32),
        .ID_W   (3),
        .MAX_OUT(4)
    ) dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .ifu_ar_valid    (ifu_ar_valid),
        .ifu_ar_ready    (ifu_ar_ready),
        .ifu_ar_addr     (ifu_ar_addr),
        .ifu_ar_id       (ifu_ar_id),
        .lsu_ar_valid    (lsu_ar_valid),
        .lsu_ar_ready    (lsu_ar_ready),
        .lsu_ar_addr     (lsu_ar_addr),
        .lsu_ar_id       (lsu_ar_id),
        .axi_arvalid     (axi_arvalid),
        .axi_arready     (axi_arready),
        .axi_araddr      (axi_araddr),
        .axi_arid        (axi_arid),
        .axi_rvalid      (axi_rvalid),
        .axi_rlast       (axi_rlast),
        .axi_rid         (axi_rid),
        .axi_rready      (axi_rready),
        .ifu_r_valid     (ifu_r_valid),
        .ifu_r_ready     (ifu_r_ready),
        .lsu_r_valid     (lsu_r_valid),
        .lsu_r_ready     (lsu_r_ready),
        .r_id            (r_id),
        .err_unexpected_r(err_unexpected_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_ar_valid = 1'b0;
        ifu_ar_addr  = '0;
        ifu_ar_id    = '0;
        lsu_ar_valid = 1'b0;
        lsu_ar_addr  = '0;
        lsu_ar_id    = '0;
        axi_arready  = 1'b0;
        axi_rvalid   = 1'b0;
        axi_rlast    = 1'b0;
        axi_rid      = '0;
        ifu_r_ready  = 1'b0;
        lsu_r_ready  = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst_l = 1'b0;
        tick();
        tick();
        rst_l = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #2;
        checks++;
        if (axi_arvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_arvalid: got %b expected 0", axi_arvalid);
        end
        checks++;
        if (axi_araddr !== 32'h0 || axi_arid !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_slot: got addr %h id %h expected 0/0", axi_araddr, axi_arid);
        end
        checks++;
        if (dut.cnt_ifu !== 3'd0 || dut.cnt_lsu !== 3'd0 || err_unexpected_r !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_cnt: got ifu %0d lsu %0d err %b expected 0 0 0",
                     dut.cnt_ifu, dut.cnt_lsu, err_unexpected_r);
        end
        checks++;
        if (ifu_ar_ready !== 1'b0 || lsu_ar_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b%b expected 00", ifu_ar_ready, lsu_ar_ready);
        end
        tick();
    endtask

    task automatic test_single_ifu();
        apply_reset();
        ifu_ar_valid = 1'b1;
        ifu_ar_addr  = 32'h1000;
        ifu_ar_id    = 3'd2;
        axi_arready  = 1'b1;
        #2;
        checks++;
        if (ifu_ar_ready !== 1'b1 || lsu_ar_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_ready: got ifu %b lsu %b expected 1 0", ifu_ar_ready, lsu_ar_ready);
        end
        tick();
        ifu_ar_valid = 1'b0;
        #2;
        checks++;
        if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h1000 || axi_arid !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL single_slot: got v %b addr %h id %b expected 1 1000 0010",
                     axi_arvalid, axi_araddr, axi_arid);
        end
        checks++;
        if (dut.cnt_ifu !== 3'd0) begin
            errors++;
            $display("[TB] FAIL single_cnt_pre: got %0d expected 0", dut.cnt_ifu);
        end
        tick();
        #2;
        checks++;
        if (dut.cnt_ifu !== 3'd1 || axi_arvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_cnt_post: got cnt %0d v %b expected 1 0", dut.cnt_ifu, axi_arvalid);
        end
        axi_rvalid  = 1'b1;
        axi_rlast   = 1'b1;
        axi_rid     = 4'b0010;
        ifu_r_ready = 1'b1;
        #1;
        checks++;
        if (ifu_r_valid !== 1'b1 || lsu_r_valid !== 1'b0 || axi_rready !== 1'b1 || r_id !== 3'd2) begin
            errors++;
            $display("[TB] FAIL single_rroute: got iv %b lv %b rr %b rid %0d expected 1 0 1 2",
                     ifu_r_valid, lsu_r_valid, axi_rready, r_id);
        end
        tick();
        clear_inputs();
        #2;
        checks++;
        if (dut.cnt_ifu !== 3'd0 || err_unexpected_r !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_cnt_drain: got cnt %0d err %b expected 0 0", dut.cnt_ifu, err_unexpected_r);
        end
    endtask

    task automatic test_round_robin();
        logic exp_lsu;
        apply_reset();
        ifu_ar_valid = 1'b1;
        ifu_ar_addr  = 32'h2000;
        ifu_ar_id    = 3'd1;
        lsu_ar_valid = 1'b1;
        lsu_ar_addr  = 32'h3000;
        lsu_ar_id    = 3'd5;
        axi_arready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_lsu = (k % 2) == 1;
            #2;
            if (k > 0) begin
                checks++;
                if (axi_arvalid !== 1'b1 || axi_arid[3] !== ~exp_lsu) begin
                    errors++;
                    $display("[TB] FAIL rr_arid%0d: got v %b msb %b expected 1 %b",
                             k - 1, axi_arvalid, axi_arid[3], ~exp_lsu);
                end
            end
            checks++;
            if (ifu_ar_ready !== ~exp_lsu || lsu_ar_ready !== exp_lsu) begin
                errors++;
                $display("[TB] FAIL rr_grant%0d: got ifu %b lsu %b expected %b %b",
                         k, ifu_ar_ready, lsu_ar_ready, ~exp_lsu, exp_lsu);
            end
            tick();
        end
        ifu_ar_valid = 1'b0;
        lsu_ar_valid = 1'b0;
        #2;
        checks++;
        if (axi_arid !== 4'b1101 || axi_araddr !== 32'h3000) begin
            errors++;
            $display("[TB] FAIL rr_last_slot: got id %b addr %h expected 1101 3000", axi_arid, axi_araddr);
        end
        tick();
        #2;
        checks++;
        if (dut.cnt_ifu !== 3'd2 || dut.cnt_lsu !== 3'd2) begin
            errors++;
            $display("[TB] FAIL rr_counts: got ifu %0d lsu %0d expected 2 2", dut.cnt_ifu, dut.cnt_lsu);
        end
    endtask

    task automatic test_max_outstanding();
        apply_reset();
        axi_arready  = 1'b1;
        ifu_ar_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ifu_ar_addr = 32'h4000 + 32'(k * 4);
            ifu_ar_id   = 3'(k);
            #2;
            checks++;
            if (ifu_ar_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL max_issue%0d: got %b expected 1", k, ifu_ar_ready);
            end
            tick();
        end
        ifu_ar_valid = 1'b0;
        tick();
        ifu_ar_valid = 1'b1;
        ifu_ar_addr  = 32'h4010;
        lsu_ar_valid = 1'b1;
        lsu_ar_addr  = 32'h6000;
        lsu_ar_id    = 3'd7;
        #2;
        checks++;
        if (dut.cnt_ifu !== 3'd4 || ifu_ar_ready !== 1'b0 || lsu_ar_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL max_block: got cnt %0d ifu %b lsu %b expected 4 0 1",
                     dut.cnt_ifu, ifu_ar_ready, lsu_ar_ready);
        end
        tick();
        lsu_ar_valid = 1'b0;
        axi_rvalid   = 1'b1;
        axi_rlast    = 1'b1;
        axi_rid      = 4'b0001;
        ifu_r_ready  = 1'b1;
        #2;
        checks++;
        if (ifu_ar_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL max_same_cycle_dec: got %b expected 0", ifu_ar_ready);
        end
        tick();
        axi_rvalid  = 1'b0;
        axi_rlast   = 1'b0;
        ifu_r_ready = 1'b0;
        #2;
        checks++;
        if (dut.cnt_ifu !== 3'd3 || ifu_ar_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL max_unblock: got cnt %0d ready %b expected 3 1", dut.cnt_ifu, ifu_ar_ready);
        end
        tick();
        ifu_ar_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        apply_reset();
        ifu_ar_valid = 1'b1;
        ifu_ar_addr  = 32'h5000;
        ifu_ar_id    = 3'd3;
        tick();
        ifu_ar_valid = 1'b0;
        lsu_ar_valid = 1'b1;
        lsu_ar_addr  = 32'h7000;
        lsu_ar_id    = 3'd4;
        for (int k = 0; k < 3; k++) begin
            #2;
            checks++;
            if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h5000 || axi_arid !== 4'b0011 ||
                ifu_ar_ready !== 1'b0 || lsu_ar_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got v %b addr %h id %b rdy %b%b expected 1 5000 0011 00",
                         k, axi_arvalid, axi_araddr, axi_arid, ifu_ar_ready, lsu_ar_ready);
            end
            tick();
        end
        axi_arready = 1'b1;
        #2;
        checks++;
        if (axi_arvalid !== 1'b1 || lsu_ar_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release: got v %b lsu_rdy %b expected 1 1", axi_arvalid, lsu_ar_ready);
        end
        tick();
        lsu_ar_valid = 1'b0;
        #2;
        checks++;
        if (dut.cnt_ifu !== 3'd1 || axi_arid !== 4'b1100 || axi_araddr !== 32'h7000) begin
            errors++;
            $display("[TB] FAIL bp_after: got cnt %0d id %b addr %h expected 1 1100 7000",
                     dut.cnt_ifu, axi_arid, axi_araddr);
        end
        tick();
    endtask

    task automatic test_routing_error();
        apply_reset();
        axi_rvalid  = 1'b1;
        axi_rlast   = 1'b0;
        axi_rid     = 4'b1011;
        lsu_r_ready = 1'b1;
        ifu_r_ready = 1'b0;
        #2;
        checks++;
        if (lsu_r_valid !== 1'b1 || ifu_r_valid !== 1'b0 || r_id !== 3'b011 || axi_rready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL route_lsu: got lv %b iv %b rid %b rr %b expected 1 0 011 1",
                     lsu_r_valid, ifu_r_valid, r_id, axi_rready);
        end
        tick();
        checks++;
        if (err_unexpected_r !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_nonlast: got %b expected 0", err_unexpected_r);
        end
        axi_rlast = 1'b1;
        tick();
        clear_inputs();
        #2;
        checks++;
        if (err_unexpected_r !== 1'b1 || dut.cnt_lsu !== 3'd0) begin
            errors++;
            $display("[TB] FAIL err_set: got err %b cnt %0d expected 1 0", err_unexpected_r, dut.cnt_lsu);
        end
        tick();
        tick();
        checks++;
        if (err_unexpected_r !== 1'b1) begin
            errors++;
            $display("[TB] FAIL err_sticky: got %b expected 1", err_unexpected_r);
        end
    endtask

    task automatic test_reset_mid();
        ifu_ar_valid = 1'b1;
        ifu_ar_addr  = 32'h8000;
        ifu_ar_id    = 3'd6;
        axi_arready  = 1'b0;
        tick();
        ifu_ar_valid = 1'b0;
        #2;
        checks++;
        if (axi_arvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_full: got %b expected 1", axi_arvalid);
        end
        rst_l = 1'b0;
        #1;
        checks++;
        if (axi_arvalid !== 1'b0 || axi_araddr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL mid_async: got v %b addr %h expected 0 0", axi_arvalid, axi_araddr);
        end
        checks++;
        if (dut.cnt_ifu !== 3'd0 || dut.cnt_lsu !== 3'd0 || err_unexpected_r !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_cnt: got ifu %0d lsu %0d err %b expected 0 0 0",
                     dut.cnt_ifu, dut.cnt_lsu, err_unexpected_r);
        end
        tick();
        rst_l = 1'b1;
        tick();
    endtask

    initial begin
        rst_l = 1'b1;
        clear_inputs();
        test_reset();
        test_single_ifu();
        test_round_robin();
        test_max_outstanding();
        test_backpressure();
        test_routing_error();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
